// File: rtl/tetris_pkg.sv
// Shared playfield geometry, controller state encoding and the row-full helper
// used by the piece controller and its line-clear shifter.
package tetris_pkg;

    localparam int BOARD_W    = 10;
    localparam int BOARD_H    = 20;
    localparam int BOARD_BITS = BOARD_W * BOARD_H;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN_CHK,
        FALL,
        LOCK,
        CLEAR,
        DONE,
        OVER
    } pc_state_t;

    // Board index is row*10+col with bit 0 at the top-left cell.
    function automatic logic row_full(input logic [0:BOARD_BITS-1] board,
                                      input logic [4:0]            r);
        logic       full;
        logic [7:0] base;
        full = 1'b1;
        base = 8'(r) * 8'(BOARD_W);
        for (int c = 0; c < BOARD_W; c++) begin
            full = full & board[base + 8'(c)];
        end
        return full;
    endfunction

endpackage

// File: rtl/line_clear_shifter.sv
// Combinational single-row collapse: reports whether row r is full and
// produces the board with rows 0..r-1 moved down one row and row 0 emptied.
module line_clear_shifter
    import tetris_pkg::*;
(
    input  logic [0:BOARD_BITS-1] board,
    input  logic [4:0]            r,
    output logic                  full,
    output logic [0:BOARD_BITS-1] shifted
);

    assign full = row_full(board, r);

    assign shifted[0 +: BOARD_W] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < BOARD_H; gi++) begin : g_row
            // Rows below r are untouched; rows 1..r take the row above.
            assign shifted[gi*BOARD_W +: BOARD_W] = (5'(gi) <= r)
                ? board[(gi-1)*BOARD_W +: BOARD_W]
                : board[gi*BOARD_W +: BOARD_W];
        end
    endgenerate

endmodule

// File: rtl/piece_controller.sv
// Falling-piece controller: owns the playfield and piece position, issues
// checker-approved moves, and locks the piece and clears full rows on landing.
module piece_controller
    import tetris_pkg::*;
#(
    parameter logic [3:0] SPAWN_X = 4'd3
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  spawn,
    input  logic [0:15]           piece_in,
    input  logic                  cmd_left,
    input  logic                  cmd_right,
    input  logic                  cmd_down,
    input  logic                  grav_tick,
    input  logic                  can_L,
    input  logic                  can_D,
    input  logic                  can_R,
    input  logic                  can_C,
    output logic [0:15]           piece_q,
    output logic [0:BOARD_BITS-1] board_q,
    output logic [3:0]            x_pos,
    output logic [4:0]            y_pos,
    output logic                  active,
    output logic                  lock_done,
    output logic [2:0]            lines_cleared,
    output logic                  game_over
);

    pc_state_t             state_reg, state_next;
    logic [3:0]            k_reg, k_next;
    logic [4:0]            r_reg, r_next;
    logic [2:0]            count_reg, count_next;
    logic [0:BOARD_BITS-1] board_next;
    logic [0:15]           piece_next;
    logic [3:0]            x_next;
    logic [4:0]            y_next;
    logic                  active_next;
    logic [2:0]            lines_next;
    logic                  game_over_next;

    logic                  clr_full;
    logic [0:BOARD_BITS-1] clr_board;
    logic [7:0]            lock_row;
    logic [7:0]            lock_col;
    logic [7:0]            lock_idx;
    logic                  down_req;

    line_clear_shifter u_shifter (
        .board   (board_q),
        .r       (r_reg),
        .full    (clr_full),
        .shifted (clr_board)
    );

    // Cell k of the 4x4 box maps to (y+k/4, x+k%4) on the board.
    assign lock_row = 8'(y_pos) + 8'(k_reg[3:2]);
    assign lock_col = 8'(x_pos) + 8'(k_reg[1:0]);
    assign lock_idx = lock_row * 8'(BOARD_W) + lock_col;

    assign down_req  = grav_tick | cmd_down;
    assign lock_done = (state_reg == DONE);

    always_comb begin
        state_next     = state_reg;
        k_next         = k_reg;
        r_next         = r_reg;
        count_next     = count_reg;
        board_next     = board_q;
        piece_next     = piece_q;
        x_next         = x_pos;
        y_next         = y_pos;
        active_next    = active;
        lines_next     = lines_cleared;
        game_over_next = game_over;

        case (state_reg)
            IDLE: begin
                if (spawn) begin
                    piece_next = piece_in;
                    x_next     = SPAWN_X;
                    y_next     = 5'd0;
                    state_next = SPAWN_CHK;
                end
            end

            SPAWN_CHK: begin
                if (!can_C) begin
                    game_over_next = 1'b1;
                    state_next     = OVER;
                end else begin
                    active_next = 1'b1;
                    state_next  = FALL;
                end
            end

            FALL: begin
                if (down_req) begin
                    if (can_D) begin
                        y_next = y_pos + 5'd1;
                    end else begin
                        active_next = 1'b0;
                        k_next      = 4'd0;
                        state_next  = LOCK;
                    end
                end else if (cmd_left && !cmd_right) begin
                    if (can_L) begin
                        x_next = x_pos - 4'd1;
                    end
                end else if (cmd_right && !cmd_left) begin
                    if (can_R) begin
                        x_next = x_pos + 4'd1;
                    end
                end
            end

            LOCK: begin
                // Cells hanging off the right or bottom edge are dropped.
                if (piece_q[k_reg] && (lock_col < 8'(BOARD_W)) && (lock_row < 8'(BOARD_H))) begin
                    board_next[lock_idx] = 1'b1;
                end
                if (k_reg == 4'd15) begin
                    r_next     = 5'(BOARD_H - 1);
                    count_next = 3'd0;
                    state_next = CLEAR;
                end else begin
                    k_next = k_reg + 4'd1;
                end
            end

            CLEAR: begin
                // A collapsed row is rescanned since new content dropped into it.
                if (clr_full) begin
                    board_next = clr_board;
                    if (count_reg != 3'd7) begin
                        count_next = count_reg + 3'd1;
                    end
                end else if (r_reg == 5'd0) begin
                    lines_next = count_reg;
                    state_next = DONE;
                end else begin
                    r_next = r_reg - 5'd1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            OVER: begin
                state_next = OVER;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // lines_cleared is loaded on entry to DONE so it is valid alongside lock_done.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg     <= IDLE;
            k_reg         <= 4'd0;
            r_reg         <= 5'd0;
            count_reg     <= 3'd0;
            board_q       <= '0;
            piece_q       <= '0;
            x_pos         <= 4'd0;
            y_pos         <= 5'd0;
            active        <= 1'b0;
            lines_cleared <= 3'd0;
            game_over     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            r_reg         <= r_next;
            count_reg     <= count_next;
            board_q       <= board_next;
            piece_q       <= piece_next;
            x_pos         <= x_next;
            y_pos         <= y_next;
            active        <= active_next;
            lines_cleared <= lines_next;
            game_over     <= game_over_next;
        end
    end

endmodule

// File: tb/tb_piece_controller.sv
// Bench for piece_controller: behavioural move checker in the loop, lock
// results predicted by a board model and scored when lock_done pulses.
module tb_piece_controller;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          spawn;
    logic [0:15]   piece_in;
    logic          cmd_left;
    logic          cmd_right;
    logic          cmd_down;
    logic          grav_tick;
    logic          can_L, can_D, can_R, can_C;
    logic [0:15]   piece_q;
    logic [0:199]  board_q;
    logic [3:0]    x_pos;
    logic [4:0]    y_pos;
    logic          active;
    logic          lock_done;
    logic [2:0]    lines_cleared;
    logic          game_over;

    logic          use_stub;
    logic          stub_L, stub_D, stub_R, stub_C;

    int            n_checks = 0;
    int            n_fail   = 0;

    typedef struct {
        logic [0:199] board;
        logic [2:0]   lines;
    } exp_t;

    exp_t          sb[$];
    logic [0:199]  exp_board;

    piece_controller #(.SPAWN_X(4'd3)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .spawn         (spawn),
        .piece_in      (piece_in),
        .cmd_left      (cmd_left),
        .cmd_right     (cmd_right),
        .cmd_down      (cmd_down),
        .grav_tick     (grav_tick),
        .can_L         (can_L),
        .can_D         (can_D),
        .can_R         (can_R),
        .can_C         (can_C),
        .piece_q       (piece_q),
        .board_q       (board_q),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .active        (active),
        .lock_done     (lock_done),
        .lines_cleared (lines_cleared),
        .game_over     (game_over)
    );

    always #5 Clk = ~Clk;

    function automatic bit fits(input logic [0:199] b, input logic [0:15] p, input int x, input int y);
        int r;
        int c;
        for (int k = 0; k < 16; k++) begin
            if (p[k]) begin
                r = y + k / 4;
                c = x + k % 4;
                if (c < 0 || c > 9 || r < 0 || r > 19) return 1'b0;
                if (b[r*10+c]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    always_comb begin
        can_L = use_stub ? stub_L : fits(board_q, piece_q, int'(x_pos) - 1, int'(y_pos));
        can_R = use_stub ? stub_R : fits(board_q, piece_q, int'(x_pos) + 1, int'(y_pos));
        can_D = use_stub ? stub_D : fits(board_q, piece_q, int'(x_pos), int'(y_pos) + 1);
        can_C = use_stub ? stub_C : fits(board_q, piece_q, int'(x_pos), int'(y_pos));
    end

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_lock(input logic [0:199] b, input logic [0:15] p, input int x, input int y,
                              output logic [0:199] nb, output int lines);
        int  r;
        int  c;
        int  row;
        bit  full;
        nb    = b;
        lines = 0;
        for (int k = 0; k < 16; k++) begin
            if (p[k]) begin
                r = y + k / 4;
                c = x + k % 4;
                if (c >= 0 && c < 10 && r >= 0 && r < 20) nb[r*10+c] = 1'b1;
            end
        end
        row = 19;
        while (row >= 0) begin
            full = 1'b1;
            for (int cc = 0; cc < 10; cc++) if (!nb[row*10+cc]) full = 1'b0;
            if (full) begin
                for (int rr = row; rr > 0; rr--)
                    for (int cc = 0; cc < 10; cc++) nb[rr*10+cc] = nb[(rr-1)*10+cc];
                for (int cc = 0; cc < 10; cc++) nb[cc] = 1'b0;
                if (lines < 7) lines++;
            end else begin
                row--;
            end
        end
    endtask

    always @(negedge Clk) begin
        if (lock_done) begin
            if (sb.size() == 0) begin
                check("unexpected_lock_done", 200'(lock_done), 200'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("lines_cleared", 200'(lines_cleared), 200'(e.lines));
                check("board_after_lock", board_q, e.board);
                $display("lock_done: lines_cleared=%0d", lines_cleared);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic mv(input bit l, input bit r, input bit d, input bit g);
        cmd_left  = l;
        cmd_right = r;
        cmd_down  = d;
        grav_tick = g;
        step();
        cmd_left  = 1'b0;
        cmd_right = 1'b0;
        cmd_down  = 1'b0;
        grav_tick = 1'b0;
    endtask

    task automatic spawn_piece(input logic [15:0] p);
        piece_in = p;
        spawn    = 1'b1;
        step();
        spawn    = 1'b0;
        step();
    endtask

    task automatic drop_piece(input bit push, output int nl);
        logic [0:199] nb;
        int           lines;
        int           ticks;
        ticks = 0;
        lines = 0;
        nb    = board_q;
        while (active && ticks < 25) begin
            model_lock(board_q, piece_q, int'(x_pos), int'(y_pos), nb, lines);
            mv(1'b0, 1'b0, 1'b0, 1'b1);
            ticks++;
        end
        check("drop_locked", 200'(active), 200'(0));
        if (push) begin
            sb.push_back('{board: nb, lines: 3'(lines)});
            exp_board = nb;
        end
        nl = lines;
    endtask

    task automatic wait_lock(input int nlines);
        int cnt;
        bit seen;
        cnt  = 1;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            cnt++;
            if (lock_done) seen = 1'b1;
        end
        check("lock_done_seen", 200'(lock_done), 200'(1));
        check("lock_latency", 200'(cnt), 200'(37 + nlines));
        step();
        check("lock_done_pulse", 200'(lock_done), 200'(0));
    endtask

    task automatic place(input logic [15:0] p, input int dx);
        int nl;
        spawn_piece(p);
        for (int i = 0; i < dx; i++) mv(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < -dx; i++) mv(1'b1, 1'b0, 1'b0, 1'b0);
        drop_piece(1'b1, nl);
        wait_lock(nl);
    endtask

    task automatic build_gap_rows();
        place(16'hCC00, -3);
        place(16'h8800, -1);
        place(16'hCC00, 4);
        place(16'h8800, 6);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        exp_board = '0;
    endtask

    initial begin
        int nl;
        int seen_cnt;
        Reset_n   = 1'b0;
        spawn     = 1'b0;
        piece_in  = '0;
        cmd_left  = 1'b0;
        cmd_right = 1'b0;
        cmd_down  = 1'b0;
        grav_tick = 1'b0;
        use_stub  = 1'b0;
        stub_L    = 1'b0;
        stub_D    = 1'b0;
        stub_R    = 1'b0;
        stub_C    = 1'b0;
        exp_board = '0;
        step();
        step();
        check("rst_board", board_q, 200'(0));
        check("rst_piece", 200'(piece_q), 200'(0));
        check("rst_x", 200'(x_pos), 200'(0));
        check("rst_y", 200'(y_pos), 200'(0));
        check("rst_active", 200'(active), 200'(0));
        check("rst_lock_done", 200'(lock_done), 200'(0));
        check("rst_lines", 200'(lines_cleared), 200'(0));
        check("rst_game_over", 200'(game_over), 200'(0));
        Reset_n = 1'b1;
        step();

        // 1: horizontal I falls to the floor and locks into row 19
        mv(1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_ignores_tick", 200'(y_pos), 200'(0));
        spawn_piece(16'h0F00);
        check("spawn_x", 200'(x_pos), 200'(3));
        check("spawn_y", 200'(y_pos), 200'(0));
        check("spawn_active", 200'(active), 200'(1));
        check("spawn_piece_q", 200'(piece_q), 200'(16'h0F00));
        for (int i = 1; i <= 18; i++) begin
            mv(1'b0, 1'b0, 1'b0, 1'b1);
            check("fall_y", 200'(y_pos), 200'(i));
            check("fall_x", 200'(x_pos), 200'(3));
        end
        drop_piece(1'b1, nl);
        wait_lock(nl);
        check("row19_bits", 200'(board_q[193:196]), 200'(4'hF));

        // 2: simultaneous left/right cancels; down wins over left
        spawn_piece(16'h0F00);
        mv(1'b1, 1'b1, 1'b0, 1'b0);
        check("lr_same_cycle_x", 200'(x_pos), 200'(3));
        mv(1'b1, 1'b0, 1'b0, 1'b1);
        check("down_over_left_x", 200'(x_pos), 200'(3));
        check("down_over_left_y", 200'(y_pos), 200'(1));
        mv(1'b0, 1'b0, 1'b1, 1'b0);
        check("cmd_down_y", 200'(y_pos), 200'(2));
        mv(1'b0, 1'b1, 1'b0, 1'b0);
        check("right_x", 200'(x_pos), 200'(4));
        drop_piece(1'b1, nl);
        wait_lock(nl);

        // 3: line clears into a prepared gap, single then double
        do_reset();
        spawn_piece(16'hCC00);
        for (int i = 0; i < 3; i++) mv(1'b1, 1'b0, 1'b0, 1'b0);
        check("left_to_wall_x", 200'(x_pos), 200'(0));
        mv(1'b1, 1'b0, 1'b0, 1'b0);
        check("left_refused_x", 200'(x_pos), 200'(0));
        drop_piece(1'b1, nl);
        wait_lock(nl);
        place(16'h8800, -1);
        place(16'hCC00, 4);
        place(16'h8800, 6);
        place(16'h0F00, 0);
        place(16'h0F00, 0);
        check("board_empty_after_clears", board_q, 200'(0));
        build_gap_rows();
        place(16'hFF00, 0);

        // 4: blocked spawn ends the game until reset
        do_reset();
        for (int i = 0; i < 5; i++) place(16'h8888, 0);
        piece_in = 16'h0F00;
        spawn    = 1'b1;
        step();
        spawn    = 1'b0;
        step();
        check("over_game_over", 200'(game_over), 200'(1));
        check("over_active", 200'(active), 200'(0));
        piece_in  = 16'hFFFF;
        spawn     = 1'b1;
        cmd_left  = 1'b1;
        grav_tick = 1'b1;
        repeat (3) step();
        spawn     = 1'b0;
        cmd_left  = 1'b0;
        grav_tick = 1'b0;
        check("over_piece_held", 200'(piece_q), 200'(16'h0F00));
        check("over_x_held", 200'(x_pos), 200'(3));
        check("over_y_held", 200'(y_pos), 200'(0));
        check("over_board_held", board_q, exp_board);
        check("over_sticky", 200'(game_over), 200'(1));
        do_reset();
        check("over_reset_game_over", 200'(game_over), 200'(0));
        check("over_reset_board", board_q, 200'(0));

        // 5: reset in the middle of the row scan aborts the lock
        spawn_piece(16'h0F00);
        drop_piece(1'b0, nl);
        model_lock('0, 16'h0F00, 3, 18, exp_board, nl);
        repeat (25) step();
        check("mid_clear_board", board_q, exp_board);
        do_reset();
        check("mid_clear_rst_board", board_q, 200'(0));
        check("mid_clear_rst_active", 200'(active), 200'(0));
        check("mid_clear_rst_x", 200'(x_pos), 200'(0));
        seen_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (lock_done) seen_cnt++;
        end
        check("mid_clear_no_lock_done", 200'(seen_cnt), 200'(0));

        // 6: piece hanging past column 9 locks only its in-range cells
        use_stub = 1'b1;
        stub_C   = 1'b1;
        stub_L   = 1'b1;
        stub_R   = 1'b1;
        stub_D   = 1'b1;
        spawn_piece(16'h0660);
        for (int i = 0; i < 5; i++) mv(1'b0, 1'b1, 1'b0, 1'b0);
        check("edge_x", 200'(x_pos), 200'(8));
        stub_R = 1'b0;
        mv(1'b0, 1'b1, 1'b0, 1'b0);
        check("edge_right_refused", 200'(x_pos), 200'(8));
        stub_D = 1'b0;
        drop_piece(1'b1, nl);
        wait_lock(nl);
        check("edge_no_wrap_bit20", 200'(board_q[20]), 200'(0));
        check("edge_bit19", 200'(board_q[19]), 200'(1));
        use_stub = 1'b0;

        step();
        check("scoreboard_drained", 200'(sb.size()), 200'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
